phv_action_aligner: RTL and testbench



---
 rtl/phv_action_aligner.sv | 136 +++++++++++++
 tb/tb_phv_action_aligner.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_action_aligner.sv
// Pairs each PHV with its later-arriving action word through two in-order FIFOs and one output register.
// Optional build macro ALIGN_ERR_CNT_EN adds align_err_cnt, a saturating count of orphan actions.
module phv_action_aligner #(
  parameter int PHV_LEN    = 2304,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_ready_out,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
  input  logic                          action_in_valid,
  output logic                          action_ready_out,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_out_valid,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
  output logic                          action_out_valid,
  input  logic                          ready_in
`ifdef ALIGN_ERR_CNT_EN
  ,
  output logic [15:0]                   align_err_cnt
`endif
);

  localparam int AW = ACT_LEN * C_NUM_PHVS;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t state_q, state_d;

  logic [PHV_LEN-1:0] phv_mem [FIFO_DEPTH];
  logic [AW-1:0]      act_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] phv_wr_ptr, phv_rd_ptr, act_wr_ptr, act_rd_ptr;
  logic [ADDR_W:0]   phv_count, act_count;
  logic              phv_push, act_push, pop;

  // Readiness comes from registered counts only, so a full FIFO refuses even when it pops this cycle.
  assign phv_ready_out    = (phv_count != DEPTH_CNT);
  assign action_ready_out = (act_count != DEPTH_CNT);
  assign phv_push         = phv_in_valid && phv_ready_out;
  assign act_push         = action_in_valid && action_ready_out;
  assign pop              = (phv_count != '0) && (act_count != '0) && (!phv_out_valid || ready_in);

  always_ff @(posedge clk) begin
    if (phv_push) phv_mem[phv_wr_ptr] <= phv_in;
    if (act_push) act_mem[act_wr_ptr] <= action_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_wr_ptr <= '0;
      phv_rd_ptr <= '0;
      phv_count  <= '0;
    end else begin
      if (phv_push) phv_wr_ptr <= phv_wr_ptr + PTR_ONE;
      if (pop)      phv_rd_ptr <= phv_rd_ptr + PTR_ONE;
      case ({phv_push, pop})
        2'b10:   phv_count <= phv_count + CNT_ONE;
        2'b01:   phv_count <= phv_count - CNT_ONE;
        default: phv_count <= phv_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_wr_ptr <= '0;
      act_rd_ptr <= '0;
      act_count  <= '0;
    end else begin
      if (act_push) act_wr_ptr <= act_wr_ptr + PTR_ONE;
      if (pop)      act_rd_ptr <= act_rd_ptr + PTR_ONE;
      case ({act_push, pop})
        2'b10:   act_count <= act_count + CNT_ONE;
        2'b01:   act_count <= act_count - CNT_ONE;
        default: act_count <= act_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (pop) state_d = S_FULL;
      S_FULL: begin
        if (pop)           state_d = S_FULL;
        else if (ready_in) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign phv_out_valid    = (state_q == S_FULL);
  assign action_out_valid = (state_q == S_FULL);

  // Data only changes on a pop, which keeps a stalled pair bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out    <= '0;
      action_out <= '0;
    end else if (pop) begin
      phv_out    <= phv_mem[phv_rd_ptr];
      action_out <= act_mem[act_rd_ptr];
    end
  end

`ifdef ALIGN_ERR_CNT_EN
  // A pop removes one entry from each FIFO, so it cancels out of the comparison.
  logic [ADDR_W+1:0] act_lvl, phv_lvl;
  assign act_lvl = {1'b0, act_count} + (ADDR_W + 2)'(1);
  assign phv_lvl = {1'b0, phv_count} + (ADDR_W + 2)'(phv_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err_cnt <= '0;
    else if (act_push && (act_lvl > phv_lvl) && (align_err_cnt != 16'hFFFF))
      align_err_cnt <= align_err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_phv_action_aligner.sv
// Randomised and directed bench for phv_action_aligner against a queue-based pairing model.
// Build with ALIGN_ERR_CNT_EN defined to also exercise the orphan-action counter.
module tb_phv_action_aligner;
  localparam int PHV_LEN    = 2304;
  localparam int ACT_LEN    = 64;
  localparam int C_NUM_PHVS = 65;
  localparam int AW         = ACT_LEN * C_NUM_PHVS;
  localparam int DEPTH      = 4;

  typedef logic [PHV_LEN-1:0] phv_t;
  typedef logic [AW-1:0]      act_t;

  logic clk, rst_n;
  phv_t phv_in, phv_out;
  act_t action_in, action_out;
  logic phv_in_valid, phv_ready_out, action_in_valid, action_ready_out;
  logic phv_out_valid, action_out_valid, ready_in;
`ifdef ALIGN_ERR_CNT_EN
  logic [15:0] align_err_cnt;
`endif

  phv_action_aligner #(
    .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .C_NUM_PHVS(C_NUM_PHVS),
    .FIFO_DEPTH(DEPTH), .ADDR_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_ready_out(phv_ready_out),
    .action_in(action_in), .action_in_valid(action_in_valid), .action_ready_out(action_ready_out),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .action_out(action_out), .action_out_valid(action_out_valid),
    .ready_in(ready_in)
`ifdef ALIGN_ERR_CNT_EN
    , .align_err_cnt(align_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: two unbounded-order queues holding what has been accepted, plus the presented pair.
  phv_t m_phv_q[$];
  act_t m_act_q[$];
  logic m_valid;
  phv_t m_phv_out;
  act_t m_act_out;
  int   m_err;
  bit   check_en = 0;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic chk_phv(input string name, input phv_t actual, input phv_t required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual[63:0]=%h required[63:0]=%h t=%0t", name, actual[63:0], required[63:0], $time);
    end
  endtask

  task automatic chk_act(input string name, input act_t actual, input act_t required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual[63:0]=%h required[63:0]=%h t=%0t", name, actual[63:0], required[63:0], $time);
    end
  endtask

  function automatic phv_t rand_phv();
    phv_t r;
    for (int i = 0; i < PHV_LEN / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic act_t rand_act();
    act_t r;
    for (int i = 0; i < AW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_clear();
    m_phv_q.delete();
    m_act_q.delete();
    m_valid   = 1'b0;
    m_phv_out = '0;
    m_act_out = '0;
    m_err     = 0;
  endtask

  // Applies the inputs of the coming edge to the model.
  task automatic model_update();
    bit pp, ap, pop;
    pp  = phv_in_valid && (m_phv_q.size() < DEPTH);
    ap  = action_in_valid && (m_act_q.size() < DEPTH);
    pop = (m_phv_q.size() > 0) && (m_act_q.size() > 0) && (!m_valid || ready_in);
    if (pop) begin
      m_phv_out = m_phv_q.pop_front();
      m_act_out = m_act_q.pop_front();
      m_valid   = 1'b1;
    end else if (ready_in) begin
      m_valid = 1'b0;
    end
    if (pp) m_phv_q.push_back(phv_in);
    if (ap) m_act_q.push_back(action_in);
    if (ap && (m_act_q.size() > m_phv_q.size())) m_err = (m_err < 65535) ? m_err + 1 : 65535;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("phv_ready", phv_ready_out, m_phv_q.size() < DEPTH);
      chk("action_ready", action_ready_out, m_act_q.size() < DEPTH);
      chk("phv_valid", phv_out_valid, m_valid);
      chk("action_valid", action_out_valid, m_valid);
      chk_phv("phv_out", phv_out, m_phv_out);
      chk_act("action_out", action_out, m_act_out);
`ifdef ALIGN_ERR_CNT_EN
      chk("align_err_cnt", align_err_cnt, 64'(m_err));
`endif
    end
  end

  // Inputs are set just after a negedge; one step crosses one rising edge and lands after the next negedge.
  task automatic step();
    if (rst_n) model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    phv_in_valid    = 1'b0;
    action_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    step();
    step();
    rst_n = 1'b1;
  endtask

  phv_t idx_phv, held_phv;
  act_t idx_act, held_act;
  int run, max_run;

  initial begin
    rst_n = 1'b0;
    phv_in = '0;
    action_in = '0;
    ready_in = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    #1;
    check_en = 1;
    step();
    rst_n = 1'b1;

    // Single pair: pushed at edge 0, presented after edge 1, gone after edge 2.
    idx_phv = '0;
    for (int i = 0; i < 64; i++) idx_phv[i*32 +: 32] = 32'(i);
    for (int i = 0; i < C_NUM_PHVS; i++) idx_act[i*64 +: 64] = 64'h100 + 64'(i);
    phv_in = idx_phv;
    action_in = idx_act;
    phv_in_valid = 1'b1;
    action_in_valid = 1'b1;
    step();
    idle_inputs();
    chk("t1_valid_c1", phv_out_valid, 0);
    step();
    chk("t1_valid_c2", phv_out_valid, 1);
    chk_phv("t1_phv", phv_out, idx_phv);
    chk_act("t1_act", action_out, idx_act);
    step();
    chk("t1_valid_c3", phv_out_valid, 0);

    // Three PHVs first, actions trailing by five cycles each.
    for (int k = 0; k < 3; k++) begin
      phv_in = {72{32'(k + 10)}};
      phv_in_valid = 1'b1;
      step();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      action_in = {130{32'(k + 20)}};
      action_in_valid = 1'b1;
      step();
      action_in_valid = 1'b0;
      chk("t2_valid_early", phv_out_valid, 0);
      step();
      chk("t2_valid", phv_out_valid, 1);
      chk_phv("t2_phv", phv_out, {72{32'(k + 10)}});
      chk_act("t2_act", action_out, {130{32'(k + 20)}});
    end
    step();

    // Stall: first pair must stay bit-stable while both FIFOs fill and refuse.
    ready_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      phv_in = rand_phv();
      action_in = rand_act();
      phv_in_valid = 1'b1;
      action_in_valid = 1'b1;
      step();
      if (i == 1) begin
        held_phv = phv_out;
        held_act = action_out;
      end else if (i > 1) begin
        chk_phv("t3_hold_phv", phv_out, held_phv);
        chk_act("t3_hold_act", action_out, held_act);
      end
    end
    chk("t3_phv_ready_full", phv_ready_out, 0);
    chk("t3_act_ready_full", action_ready_out, 0);
    idle_inputs();
    ready_in = 1'b1;
    repeat (8) step();

    // Back-to-back stream of 50 pairs.
    run = 0;
    max_run = 0;
    for (int i = 0; i < 53; i++) begin
      phv_in = rand_phv();
      action_in = rand_act();
      phv_in_valid = (i < 50);
      action_in_valid = (i < 50);
      step();
      run = phv_out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("t4_stream_run", 64'(max_run), 50);

    // Reset while output is full and both FIFOs hold two entries.
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phv_in = rand_phv();
      action_in = rand_act();
      phv_in_valid = 1'b1;
      action_in_valid = 1'b1;
      step();
    end
    idle_inputs();
    chk("t5_pre_valid", phv_out_valid, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_async_phv_valid", phv_out_valid, 0);
    chk("t5_async_act_valid", action_out_valid, 0);
    chk("t5_async_phv_ready", phv_ready_out, 1);
    chk("t5_async_act_ready", action_ready_out, 1);
    step();
    step();
    rst_n = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_stale", phv_out_valid, 0);
    end

    // Random traffic and backpressure.
    for (int i = 0; i < 3000; i++) begin
      phv_in = rand_phv();
      action_in = rand_act();
      phv_in_valid = ($urandom_range(0, 99) < 55);
      action_in_valid = ($urandom_range(0, 99) < 55);
      ready_in = ($urandom_range(0, 99) < 70);
      step();
    end
    idle_inputs();
    ready_in = 1'b1;
    repeat (8) step();

`ifdef ALIGN_ERR_CNT_EN
    do_reset();
    action_in = rand_act();
    action_in_valid = 1'b1;
    repeat (3) step();
    idle_inputs();
    chk("err_three_orphans", align_err_cnt, 3);
    do_reset();
    // One leading orphan keeps every subsequent lock-step action ahead of its PHV.
    action_in_valid = 1'b1;
    step();
    phv_in_valid = 1'b1;
    repeat (70000) step();
    idle_inputs();
    step();
    chk("err_saturated", align_err_cnt, 16'hFFFF);
    repeat (4) step();
`endif

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
